// File: rtl/frame_pkg.sv
// Shared definitions for the frame_gen / frame_checker video stream:
// pattern selects, checker FSM encoding and default frame geometry.
package frame_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_BPP    = 8;

  localparam logic [2:0] SEL_BLACK = 3'b000;
  localparam logic [2:0] SEL_WHITE = 3'b001;
  localparam logic [2:0] SEL_GRAD  = 3'b010;
  localparam logic [2:0] SEL_CHECK = 3'b011;
  localparam logic [2:0] SEL_LOGO  = 3'b100;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FRAME  = 2'd1;
  localparam state_t ST_LINE   = 2'd2;
  localparam state_t ST_REPORT = 2'd3;

  // Only the four generated patterns have a known pixel value to compare against.
  function automatic logic sel_compares(input logic [2:0] s);
    return (s == SEL_BLACK) || (s == SEL_WHITE) || (s == SEL_GRAD) || (s == SEL_CHECK);
  endfunction

endpackage

// File: rtl/frame_checker_pattern_ref.sv
// Combinational reference pattern: expected pixel for a given select and
// (column, line) position. Shared with frame_gen.
module frame_pattern_ref
  import frame_pkg::*;
#(
  parameter int BPP        = DEF_BPP,
  parameter int CHECK_SIZE = 32,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic [2:0]     sel_i,
  input  logic [XW-1:0]  x_i,
  input  logic [YW-1:0]  y_i,
  output logic [BPP-1:0] pix_o
);

  localparam int CS_LOG = $clog2(CHECK_SIZE);

  logic [BPP-1:0] grad;
  logic           x_blk;
  logic           y_blk;
  logic           unused_bits;

  if (XW >= BPP) begin : g_grad_trunc
    assign grad = x_i[BPP-1:0];
  end else begin : g_grad_ext
    assign grad = {{(BPP-XW){1'b0}}, x_i};
  end

  // CHECK_SIZE is a power of two, so the square index parity is one bit.
  if (CS_LOG < XW) begin : g_xblk
    assign x_blk = x_i[CS_LOG];
  end else begin : g_xblk_zero
    assign x_blk = 1'b0;
  end

  if (CS_LOG < YW) begin : g_yblk
    assign y_blk = y_i[CS_LOG];
  end else begin : g_yblk_zero
    assign y_blk = 1'b0;
  end

  assign unused_bits = ^{x_i, y_i};

  always_comb begin
    case (sel_i)
      SEL_BLACK: pix_o = '0;
      SEL_WHITE: pix_o = '1;
      SEL_GRAD:  pix_o = grad;
      SEL_CHECK: pix_o = {BPP{x_blk ^ y_blk}};
      default:   pix_o = '0;
    endcase
  end

endmodule

// File: rtl/frame_checker.sv
// Receive-side monitor for the fval/lval/dval video stream: checks frame
// geometry, protocol ordering and pixel content, one status bundle per frame.
module frame_checker
  import frame_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int BPP        = DEF_BPP,
  parameter int CHECK_SIZE = 32,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic             fval,
  input  logic             lval,
  input  logic             dval,
  input  logic [BPP-1:0]   pix_data,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             width_err,
  output logic             height_err,
  output logic             proto_err,
  output logic [ERR_W-1:0] pix_err_cnt,
  output logic [31:0]      checksum,
  output logic [15:0]      frame_cnt
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]    X_MAX    = '1;
  localparam logic [YW-1:0]    Y_MAX    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [XW-1:0]    WIDTH_X  = XW'(WIDTH);
  localparam logic [YW-1:0]    HEIGHT_Y = YW'(HEIGHT);

  logic           fval_q, lval_q, dval_q, en_q;
  logic [2:0]     sel_q;
  logic [BPP-1:0] pix_q;
  logic           fval_p_q, lval_p_q, sampled_q, armed_q;

  state_t           state_q, state_d;
  logic [2:0]       fsel_q, fsel_d;
  logic [XW-1:0]    x_q, x_d, x_cur;
  logic             x_ovf_q, x_ovf_d, x_ovf_cur;
  logic [YW-1:0]    y_q, y_d;
  logic             y_ovf_q, y_ovf_d;
  logic             wflag_q, wflag_d, pflag_q, pflag_d;
  logic [ERR_W-1:0] perr_q, perr_d;
  logic [31:0]      sum_q, sum_d;
  logic             hold_q, hold_d, hold_en_q, hold_en_d;
  logic [2:0]       hold_sel_q, hold_sel_d;

  logic             done_q, done_d, ok_q, ok_d, werr_q, werr_d;
  logic             herr_q, herr_d, proto_q, proto_d;
  logic [ERR_W-1:0] perr_out_q, perr_out_d;
  logic [31:0]      csum_q, csum_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic           fval_rise, fval_fall, lval_rise, lval_fall;
  logic           in_frame, pix_stb, pix_bad, line_close, height_bad;
  logic [BPP-1:0] exp_pix;

  // armed_q blocks a false fval rise when reset is released in the middle of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fval_q    <= 1'b0;
      lval_q    <= 1'b0;
      dval_q    <= 1'b0;
      en_q      <= 1'b0;
      sel_q     <= '0;
      pix_q     <= '0;
      fval_p_q  <= 1'b0;
      lval_p_q  <= 1'b0;
      sampled_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      fval_q    <= fval;
      lval_q    <= lval;
      dval_q    <= dval;
      en_q      <= en;
      sel_q     <= sel;
      pix_q     <= pix_data;
      fval_p_q  <= fval_q;
      lval_p_q  <= lval_q;
      sampled_q <= 1'b1;
      armed_q   <= armed_q | (sampled_q & ~fval_q);
    end
  end

  assign fval_rise  = fval_q & ~fval_p_q & armed_q;
  assign fval_fall  = ~fval_q & fval_p_q;
  assign lval_rise  = lval_q & ~lval_p_q;
  assign lval_fall  = ~lval_q & lval_p_q;
  assign in_frame   = (state_q == ST_FRAME) || (state_q == ST_LINE);
  assign pix_stb    = in_frame & fval_q & lval_q & dval_q;
  assign x_cur      = lval_rise ? '0 : x_q;
  assign x_ovf_cur  = lval_rise ? 1'b0 : x_ovf_q;
  assign pix_bad    = pix_stb & sel_compares(fsel_q) & (pix_q != exp_pix);
  assign line_close = (state_q == ST_LINE) & (fval_fall | lval_fall);

  frame_pattern_ref #(
    .BPP        (BPP),
    .CHECK_SIZE (CHECK_SIZE),
    .XW         (XW),
    .YW         (YW)
  ) u_pattern_ref (
    .sel_i (fsel_q),
    .x_i   (x_cur),
    .y_i   (y_q),
    .pix_o (exp_pix)
  );

  always_comb begin
    state_d    = state_q;
    fsel_d     = fsel_q;
    x_d        = x_q;
    x_ovf_d    = x_ovf_q;
    y_d        = y_q;
    y_ovf_d    = y_ovf_q;
    wflag_d    = wflag_q;
    pflag_d    = pflag_q;
    perr_d     = perr_q;
    sum_d      = sum_q;
    hold_d     = 1'b0;
    hold_en_d  = hold_en_q;
    hold_sel_d = hold_sel_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    werr_d     = werr_q;
    herr_d     = herr_q;
    proto_d    = proto_q;
    perr_out_d = perr_out_q;
    csum_d     = csum_q;
    fcnt_d     = fcnt_q;
    height_bad = y_ovf_q | (y_q != HEIGHT_Y);

    if (pix_stb) begin
      sum_d = sum_q + 32'(pix_q);
      if (x_cur == X_MAX) begin
        x_d     = X_MAX;
        x_ovf_d = 1'b1;
      end else begin
        x_d     = x_cur + XW'(1);
        x_ovf_d = x_ovf_cur;
      end
    end else if (in_frame && lval_rise) begin
      x_d     = '0;
      x_ovf_d = 1'b0;
    end

    if (pix_bad && perr_q != ERR_MAX) perr_d = perr_q + ERR_W'(1);
    if (in_frame && fval_q && dval_q && !lval_q) pflag_d = 1'b1;
    if (state_q == ST_LINE && fval_fall && lval_q) pflag_d = 1'b1;

    if (line_close) begin
      if (x_ovf_q || x_q != WIDTH_X) wflag_d = 1'b1;
      if (y_q == Y_MAX) y_ovf_d = 1'b1;
      else              y_d     = y_q + YW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if ((fval_rise && en_q) || (hold_q && hold_en_q)) begin
          fsel_d  = hold_q ? hold_sel_q : sel_q;
          x_d     = '0;
          x_ovf_d = 1'b0;
          y_d     = '0;
          y_ovf_d = 1'b0;
          wflag_d = 1'b0;
          pflag_d = 1'b0;
          perr_d  = '0;
          sum_d   = '0;
          state_d = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (fval_fall)      state_d = ST_REPORT;
        else if (lval_rise) state_d = ST_LINE;
      end
      ST_LINE: begin
        if (fval_fall)      state_d = ST_REPORT;
        else if (lval_fall) state_d = ST_FRAME;
      end
      default: begin
        // A frame may start while its predecessor reports; remember the edge.
        done_d     = 1'b1;
        werr_d     = wflag_q;
        herr_d     = height_bad;
        proto_d    = pflag_q;
        perr_out_d = perr_q;
        csum_d     = sum_q;
        ok_d       = ~(wflag_q | height_bad | pflag_q) & (perr_q == '0);
        fcnt_d     = fcnt_q + 16'd1;
        hold_d     = fval_rise;
        hold_en_d  = en_q;
        hold_sel_d = sel_q;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fsel_q     <= '0;
      x_q        <= '0;
      x_ovf_q    <= 1'b0;
      y_q        <= '0;
      y_ovf_q    <= 1'b0;
      wflag_q    <= 1'b0;
      pflag_q    <= 1'b0;
      perr_q     <= '0;
      sum_q      <= '0;
      hold_q     <= 1'b0;
      hold_en_q  <= 1'b0;
      hold_sel_q <= '0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      werr_q     <= 1'b0;
      herr_q     <= 1'b0;
      proto_q    <= 1'b0;
      perr_out_q <= '0;
      csum_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fsel_q     <= fsel_d;
      x_q        <= x_d;
      x_ovf_q    <= x_ovf_d;
      y_q        <= y_d;
      y_ovf_q    <= y_ovf_d;
      wflag_q    <= wflag_d;
      pflag_q    <= pflag_d;
      perr_q     <= perr_d;
      sum_q      <= sum_d;
      hold_q     <= hold_d;
      hold_en_q  <= hold_en_d;
      hold_sel_q <= hold_sel_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      werr_q     <= werr_d;
      herr_q     <= herr_d;
      proto_q    <= proto_d;
      perr_out_q <= perr_out_d;
      csum_q     <= csum_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign width_err   = werr_q;
  assign height_err  = herr_q;
  assign proto_err   = proto_q;
  assign pix_err_cnt = perr_out_q;
  assign checksum    = csum_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_frame_checker.sv
// Randomised scoreboard bench for frame_checker on a small 16x4 geometry;
// expected status is computed from the driven pixels by a behavioural model.
module tb_frame_checker;
  import frame_pkg::*;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int BPP = 8;
  localparam int CS  = 4;
  localparam int EW  = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [2:0]     sel = 3'b000;
  logic           fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic [BPP-1:0] pix_data = '0;
  logic           frame_done, frame_ok, width_err, height_err, proto_err;
  logic [EW-1:0]  pix_err_cnt;
  logic [31:0]    checksum;
  logic [15:0]    frame_cnt;

  typedef struct {
    logic        ok;
    logic        werr;
    logic        herr;
    logic        proto;
    int          pix_err;
    logic [31:0] sum;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = '0;

  frame_checker #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .BPP        (BPP),
    .CHECK_SIZE (CS),
    .ERR_W      (EW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sel         (sel),
    .fval        (fval),
    .lval        (lval),
    .dval        (dval),
    .pix_data    (pix_data),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .width_err   (width_err),
    .height_err  (height_err),
    .proto_err   (proto_err),
    .pix_err_cnt (pix_err_cnt),
    .checksum    (checksum),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected pixel straight from the pattern definitions; -1 means "no compare".
  function automatic int ref_pix(input logic [2:0] s, input int x, input int y);
    case (s)
      3'd0:    return 0;
      3'd1:    return (1 << BPP) - 1;
      3'd2:    return x % (1 << BPP);
      3'd3:    return (((x / CS) + (y / CS)) % 2 == 1) ? (1 << BPP) - 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic drive(input logic f, input logic l, input logic d, input logic [BPP-1:0] p);
    fval = f;
    lval = l;
    dval = d;
    pix_data = p;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [2:0] s, input logic e, input int nlines, input int short_ln,
                           input int short_len, input int corrupt_pct, input int bad_x, input int bad_y,
                           input bit stray, input bit cut, input bit joint, input int gap);
    exp_t ex;
    int   sum, perr, len, expv, v;
    bit   werr, last;
    sum  = 0;
    perr = 0;
    werr = 1'b0;
    sel  = s;
    en   = e;
    drive(1'b1, 1'b0, 1'b0, '0);
    sel = 3'($urandom_range(0, 7));
    en  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 3; k++) drive(1'b1, 1'b0, stray && k == 2, BPP'($urandom));
    for (int ln = 0; ln < nlines; ln++) begin
      last = (ln == nlines - 1);
      len  = (ln == short_ln) ? short_len : W;
      if (cut && last) len = int'($urandom_range(1, W - 1));
      for (int px = 0; px < len; px++) begin
        if ($urandom_range(0, 7) == 0) drive(1'b1, 1'b1, 1'b0, BPP'($urandom));
        expv = ref_pix(s, px, ln);
        v = (expv < 0) ? int'($urandom_range(0, 255)) : expv;
        if (int'($urandom_range(0, 99)) < corrupt_pct) v = (v + int'($urandom_range(1, 255))) % 256;
        if (px == bad_x && ln == bad_y) v = 0;
        if (expv >= 0 && v != expv) perr++;
        sum += v;
        drive(1'b1, 1'b1, 1'b1, BPP'(v));
      end
      if (len != W) werr = 1'b1;
      if (cut && last) drive(1'b0, 1'b1, 1'b0, '0);
      else if (joint && last) drive(1'b0, 1'b0, 1'b0, '0);
      else begin
        drive(1'b1, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, '0);
      end
    end
    if (!(cut || joint)) drive(1'b0, 1'b0, 1'b0, '0);
    if (e) begin
      exp_cnt++;
      ex.werr    = werr;
      ex.herr    = (nlines != H);
      ex.proto   = stray || cut;
      ex.pix_err = perr;
      ex.sum     = 32'(sum);
      ex.cnt     = exp_cnt;
      ex.ok      = !(ex.werr || ex.herr || ex.proto) && perr == 0;
      exp_q.push_back(ex);
    end
    for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: every frame_done pops one expected status bundle.
  always @(negedge clk) begin
    exp_t ex;
    if (!rst && frame_done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame_done: got frame_done=1 cnt=%0d, expected no report", frame_cnt);
      end else begin
        ex = exp_q.pop_front();
        $display("[TB] frame cnt=%0d ok=%0b w=%0b h=%0b p=%0b perr=%0d sum=%0d",
                 frame_cnt, frame_ok, width_err, height_err, proto_err, pix_err_cnt, checksum);
        chk("frame_ok", frame_ok, ex.ok);
        chk("width_err", width_err, ex.werr);
        chk("height_err", height_err, ex.herr);
        chk("proto_err", proto_err, ex.proto);
        chk("pix_err_cnt", pix_err_cnt, ex.pix_err);
        chk("checksum", checksum, ex.sum);
        chk("frame_cnt", frame_cnt, ex.cnt);
      end
    end
  end

  initial begin
    logic [2:0] s;
    logic       e;
    int         nl, sl, slen, cp, stray_mode;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_frame_done", frame_done, 0);
    chk("reset_frame_cnt", frame_cnt, 0);
    chk("reset_checksum", checksum, 0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);

    run_frame(SEL_BLACK, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 4);
    run_frame(SEL_WHITE, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 4);
    run_frame(SEL_GRAD, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 1);
    run_frame(SEL_CHECK, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 3);
    run_frame(SEL_WHITE, 1'b1, H, 1, W - 1, 0, 3, 2, 1'b0, 1'b0, 1'b0, 3);
    run_frame(SEL_WHITE, 1'b1, 3, -1, 0, 0, -1, -1, 1'b1, 1'b1, 1'b0, 3);
    run_frame(SEL_GRAD, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b1, 2);

    for (int i = 0; i < 40; i++) begin
      s    = 3'($urandom_range(0, 7));
      e    = ($urandom_range(0, 5) != 0);
      nl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(H - 1, H + 1)) : H;
      sl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      slen = int'($urandom_range(W - 3, W + 3));
      cp   = ($urandom_range(0, 2) == 0) ? 5 : 0;
      stray_mode = int'($urandom_range(0, 7));
      run_frame(s, e, nl, sl, slen, cp, -1, -1, stray_mode == 1, stray_mode == 2,
                stray_mode == 3, int'($urandom_range(1, 4)));
    end
    drain(20);

    // Reset in the middle of a frame: outputs clear at once, partial frame dropped.
    sel = SEL_WHITE;
    en  = 1'b1;
    repeat (4) drive(1'b1, 1'b0, 1'b0, '0);
    repeat (5) drive(1'b1, 1'b1, 1'b1, '1);
    #2 rst = 1'b1;
    #1;
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_width_err", width_err, 0);
    chk("rst_height_err", height_err, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_pix_err_cnt", pix_err_cnt, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    exp_cnt = '0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(1'b1, 1'b1, 1'b1, '1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0);

    run_frame(SEL_WHITE, 1'b0, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 3);
    run_frame(SEL_CHECK, 1'b1, H, -1, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 3);
    drain(20);
    repeat (5) drive(1'b0, 1'b0, 1'b0, '0);
    chk("final_frame_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_checker.md
Name: frame_checker

Overview:
- Synthesizable receive-side monitor for the frame_gen video stream (fval/lval/dval/pix_data).
- Replaces offline PGM inspection. Checks frame geometry and protocol ordering, and compares pixels against the expected pattern selected by sel.
- Reports one registered status bundle per frame.
- Sits beside frame_gen in the design and in the bench; can also tap any downstream video bus of the same format.

Parameters:
- WIDTH, 640, expected dval pixels per line
- HEIGHT, 480, expected lval pulses per frame
- BPP, 8, pixel width in bits
- CHECK_SIZE, 32, checker square edge in pixels; power of two
- ERR_W, 16, pixel-error counter width; counter saturates

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  checking enable; sampled at fval rise
- sel  in  3  expected pattern: 000 black, 001 white, 010 gradient, 011 checkers, others no pixel compare; sampled at fval rise
- fval  in  1  frame valid
- lval  in  1  line valid
- dval  in  1  data valid
- pix_data  in  BPP  pixel value, qualified by dval
- frame_done  out  1  one-cycle pulse, status valid
- frame_ok  out  1  no width, height, protocol or pixel error in last frame
- width_err  out  1  some line had dval count != WIDTH
- height_err  out  1  line count != HEIGHT
- proto_err  out  1  ordering violation in last frame
- pix_err_cnt  out  ERR_W  mismatching pixels in last frame, saturating
- checksum  out  32  sum of pix_data, zero-extended, mod 2^32, over last frame
- frame_cnt  out  16  checked frames since reset; wraps at 2^16

Behaviour:
- Reset (async, rst=1):
  - All outputs and internal state go to 0; FSM goes to IDLE.
  - Assertion mid-frame discards the partial frame; no frame_done.
- Inputs are registered once internally. Edges are detected on the registered copies.
- FSM states: IDLE, FRAME, LINE, REPORT.
- IDLE:
  - On fval rise with en=1: latch sel; clear x, y, per-frame error flags, pix_err accumulator and sum; go to FRAME.
  - On fval rise with en=0: the frame is ignored. Stay in IDLE until fval has fallen.
- FRAME (fval=1, lval=0):
  - lval rise: set x=0, go to LINE.
  - dval=1 here: set proto_err flag.
  - fval fall: go to REPORT.
- LINE:
  - Each cycle with dval=1: compare pixel, add to sum, increment x.
  - lval fall: if x != WIDTH, set width flag; increment y; go to FRAME.
  - fval fall while lval=1: set proto_err flag, count the line, check its width, go to REPORT.
  - The lval fall and fval fall in the same cycle are handled as the line close, then REPORT; no proto_err.
- Expected pixel, with x = column and y = line, both 0-based:
  - black: 0
  - white: all ones
  - gradient: x[BPP-1:0], wraps every 2^BPP columns
  - checkers: all ones if ((x/CHECK_SIZE) xor (y/CHECK_SIZE)) bit0 = 1, else 0
  - other sel: no compare; pix_err stays 0
- Counter widths: x and y are sized by $clog2 of (WIDTH+1) and (HEIGHT+1). They saturate at all ones; overflow still sets the width/height flag.
- pix_err saturates at 2^ERR_W-1.
- REPORT (one cycle):
  - Register all status outputs; height_err = (y != HEIGHT).
  - frame_ok = no error flag and pix_err = 0.
  - Pulse frame_done; increment frame_cnt; go to IDLE.
- Latency: frame_done rises 2 clk after the first clock edge that samples fval=0 (1 cycle input register, 1 cycle REPORT).
- Status outputs hold until the next REPORT.
- A new fval rise during REPORT is treated as a new frame on the next cycle (IDLE), because the registered edge is held one cycle. Back-to-back frames with 1 low cycle are therefore supported.
- sel and en changes mid-frame have no effect.

Decomposition:
- Shared package frame_pkg:
  - sel encodings SEL_BLACK, SEL_WHITE, SEL_GRAD, SEL_CHECK, SEL_LOGO
  - FSM state typedef
  - default WIDTH/HEIGHT/BPP constants, also used by frame_gen and tb
- One sub-module: frame_pattern_ref. It is combinational: (sel, x, y) -> expected pixel, parametrised by BPP and CHECK_SIZE. frame_gen can reuse it.

Test Plan:
- Black, 640x480, BPP=8, sel=000 from frame_gen -> frame_done once, frame_ok=1, pix_err_cnt=0, checksum=0, frame_cnt=1.
- White, 640x480, sel=001 -> frame_ok=1, checksum=78336000.
- WIDTH=16, HEIGHT=4, CHECK_SIZE=4, gradient, then checkers, back-to-back with 1-cycle fval low gap:
  - gradient checksum=480, frame_ok=1
  - checkers checksum=8160, frame_ok=1
  - frame_cnt=2
- 16x4 white frame with pixel (3,2) forced to 0, and one line of 15 pixels -> width_err=1, pix_err_cnt=1, frame_ok=0, height_err=0.
- dval pulse while lval=0, and fval falling mid-line -> proto_err=1, height_err=1 (3 lines counted), frame_ok=0.
- rst pulsed mid-frame, then en=0 for one frame, then a clean frame:
  - all outputs are 0 immediately on rst
  - no frame_done for the disabled frame
  - frame_cnt=1 after the clean frame
